// File: rtl/pe_drain_pkg.sv
// Shared definitions for the PE_64 output-column drain.
// Holds default widths, saturation limit constants/helpers and the FIFO entry layout.
package pe_drain_pkg;

  localparam int unsigned ACC_W_DEF = 19;
  localparam int unsigned OUT_W_DEF = 8;
  localparam int unsigned SHIFT_W   = 6;

  // Signed saturation limits for the default output width.
  localparam int SAT_MAX_DEF = (1 << (OUT_W_DEF - 1)) - 1;
  localparam int SAT_MIN_DEF = -(1 << (OUT_W_DEF - 1));

  // FIFO entry layout: tag in the MSB, element below it.
  typedef struct packed {
    logic                 propagate;
    logic [OUT_W_DEF-1:0] data;
  } drain_entry_t;

  // Saturation limits for an arbitrary signed width.
  function automatic int sat_max(input int unsigned w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int unsigned w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/pe_out_drain_fifo.sv
// drain_fifo: synchronous FIFO with a registered head output.
// Ports: CLK, RST (sync, active high); push/wdata write side; pop read side;
//        rdata = head entry (holds its last value when empty, 0 after reset);
//        count = occupancy; full / nonempty = registered status flags.
// A push while full is accepted only when a pop happens at the same edge.
module drain_fifo #(
  parameter int unsigned W     = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   nonempty
);
  import pe_drain_pkg::*;

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [CNT_W-1:0] remain_c;
  logic [CNT_W-1:0] count_nxt;
  logic             do_push;
  logic             do_pop;
  logic [W-1:0]     head_nxt;

  assign do_pop     = pop && nonempty;
  assign do_push    = push && (!full || do_pop);
  assign rd_ptr_nxt = rd_ptr + PTR_W'(do_pop);
  assign remain_c   = count - CNT_W'(do_pop);
  assign count_nxt  = remain_c + CNT_W'(do_push);

  // Next head: surviving entry if any, else the word being written, else hold.
  always_comb begin
    head_nxt = rdata;
    if (remain_c != '0) begin
      head_nxt = mem[rd_ptr_nxt];
    end else if (do_push) begin
      head_nxt = wdata;
    end
  end

  // Storage array (no reset needed; never read before written).
  always_ff @(posedge CLK) begin
    if (do_push && !RST) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers, occupancy, flags and head register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      nonempty <= 1'b0;
      rdata    <= '0;
    end else begin
      wr_ptr   <= wr_ptr + PTR_W'(do_push);
      rd_ptr   <= rd_ptr_nxt;
      count    <= count_nxt;
      full     <= (count_nxt == CNT_W'(DEPTH));
      nonempty <= (count_nxt != '0);
      rdata    <= head_nxt;
    end
  end

endmodule

// File: rtl/pe_out_drain.sv
// pe_out_drain: drains the PE_64 output column.
// Resolves carry-save words, applies round-half-up arithmetic shift, saturates
// to OUT_W and buffers into a small FIFO. The PE cannot stall, so words that
// find the FIFO full (with no pop) are dropped and counted.
// Ports: CLK, RST (sync, active high);
//        in_c {carry,sum}, in_shift, in_propagate, in_valid from the PE;
//        out_data/out_propagate/out_valid/out_ready toward writeback;
//        fifo_count occupancy; overflow sticky drop flag; drop_cnt saturating drops.
module pe_out_drain
  import pe_drain_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [2*ACC_W-1:0]       in_c,
  input  logic [SHIFT_W-1:0]       in_shift,
  input  logic                     in_propagate,
  input  logic                     in_valid,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_propagate,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int unsigned SH_W  = $clog2(ACC_W + 1);
  localparam int unsigned R_W   = ACC_W + 1;
  localparam int unsigned ENT_W = OUT_W + 1;
  localparam logic signed [R_W-1:0] R_MAX = R_W'(sat_max(OUT_W));
  localparam logic signed [R_W-1:0] R_MIN = R_W'(sat_min(OUT_W));

  // S1 registers
  logic                 s1_valid;
  logic                 s1_prop;
  logic [ACC_W-1:0]     s1_v;
  logic [SH_W-1:0]      s1_shift;
  logic [SH_W-1:0]      shift_clamp_c;

  // S2 registers
  logic                 s2_valid;
  logic                 s2_prop;
  logic signed [R_W-1:0] s2_r;

  logic signed [R_W-1:0] v_ext_c;
  logic signed [R_W-1:0] v_rnd_c;
  logic signed [R_W-1:0] r_c;
  logic [OUT_W-1:0]      sat_c;

  logic                  fifo_full;
  logic                  fifo_nonempty;
  logic [ENT_W-1:0]      head;
  logic                  pop_c;
  logic                  drop_c;

  assign shift_clamp_c = (in_shift > SHIFT_W'(ACC_W)) ? SH_W'(ACC_W) : SH_W'(in_shift);

  // S1: resolve carry-save (mod 2^ACC_W) and clamp the shift.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid <= 1'b0;
      s1_prop  <= 1'b0;
      s1_v     <= '0;
      s1_shift <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_prop  <= in_propagate;
      s1_v     <= in_c[2*ACC_W-1:ACC_W] + in_c[ACC_W-1:0];
      s1_shift <= shift_clamp_c;
    end
  end

  // Round-half-up arithmetic shift in ACC_W+1 bits so the rounding add cannot overflow.
  always_comb begin
    v_ext_c = {s1_v[ACC_W-1], s1_v};
    v_rnd_c = v_ext_c;
    r_c     = v_ext_c;
    if (s1_shift != '0) begin
      v_rnd_c = v_ext_c + (R_W'(1) << (s1_shift - SH_W'(1)));
      r_c     = v_rnd_c >>> s1_shift;
    end
  end

  // S2 register
  always_ff @(posedge CLK) begin
    if (RST) begin
      s2_valid <= 1'b0;
      s2_prop  <= 1'b0;
      s2_r     <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_prop  <= s1_prop;
      s2_r     <= r_c;
    end
  end

  // S3: saturate to the signed output width.
  always_comb begin
    sat_c = s2_r[OUT_W-1:0];
    if (s2_r > R_MAX) begin
      sat_c = R_MAX[OUT_W-1:0];
    end else if (s2_r < R_MIN) begin
      sat_c = R_MIN[OUT_W-1:0];
    end
  end

  assign pop_c  = fifo_nonempty && out_ready;
  assign drop_c = s2_valid && fifo_full && !pop_c;

  drain_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .push     (s2_valid),
    .wdata    ({s2_prop, sat_c}),
    .pop      (pop_c),
    .rdata    (head),
    .count    (fifo_count),
    .full     (fifo_full),
    .nonempty (fifo_nonempty)
  );

  assign out_propagate = head[ENT_W-1];
  assign out_data      = head[OUT_W-1:0];
  assign out_valid     = fifo_nonempty;

  // Sticky overflow and saturating drop counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop_c) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pe_out_drain.sv
`timescale 1ns/1ps
module tb_pe_out_drain;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [37:0] in_c = '0;
  logic [5:0]  in_shift = '0;
  logic        in_propagate = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  out_data;
  logic        out_propagate;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic [7:0]  drop_cnt;

  pe_out_drain #(.ACC_W(19), .OUT_W(8), .DEPTH(4), .CNT_W(8)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .in_c          (in_c),
    .in_shift      (in_shift),
    .in_propagate  (in_propagate),
    .in_valid      (in_valid),
    .out_data      (out_data),
    .out_propagate (out_propagate),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .fifo_count    (fifo_count),
    .overflow      (overflow),
    .drop_cnt      (drop_cnt)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference arithmetic: integer value, floor-rounded division, clamp.
  function automatic logic [7:0] exp_word(input logic [37:0] c, input logic [5:0] sh);
    logic [18:0] t;
    longint v, d, r;
    int s;
    t = c[37:19] + c[18:0];
    v = longint'($signed(t));
    s = (sh > 6'd19) ? 19 : int'(sh);
    if (s == 0) r = v;
    else begin
      d = longint'(1) << s;
      r = v + d / 2;
      r = (r >= 0) ? r / d : -((-r + d - 1) / d);
    end
    if (r > 127) r = 127;
    else if (r < -128) r = -128;
    return 8'(r);
  endfunction

  typedef struct { logic [7:0] data; logic prop; } ent_t;
  typedef struct { logic [7:0] data; logic prop; int due; } fl_t;

  ent_t mq[$];
  fl_t  inflight[$];
  int   edge_no = 0;
  bit   m_live = 0;
  bit   m_ovf = 0;
  int   m_drop = 0;
  ent_t m_last = '{8'd0, 1'b0};

  // Transaction-level model: a word sampled at edge N lands in the queue at edge N+2.
  always @(posedge CLK) begin
    bit   pop;
    bit   was_full;
    fl_t  f;
    edge_no++;
    if (RST) begin
      mq.delete();
      inflight.delete();
      m_ovf  = 0;
      m_drop = 0;
      m_last = '{8'd0, 1'b0};
      m_live = 1;
    end else if (m_live) begin
      pop      = (mq.size() > 0) && out_ready;
      was_full = (mq.size() == DEPTH);
      if (pop) void'(mq.pop_front());
      while (inflight.size() > 0 && inflight[0].due == edge_no) begin
        f = inflight.pop_front();
        if (was_full && !pop) begin
          m_ovf = 1;
          if (m_drop < 255) m_drop++;
        end else mq.push_back('{f.data, f.prop});
      end
      if (in_valid) inflight.push_back('{exp_word(in_c, in_shift), in_propagate, edge_no + 2});
      if (mq.size() > 0) m_last = mq[0];
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge CLK) begin
    if (m_live) begin
      chk("m_valid", out_valid, (mq.size() > 0) ? 1 : 0);
      chk("m_count", fifo_count, mq.size());
      chk("m_overflow", overflow, m_ovf);
      chk("m_drop_cnt", drop_cnt, m_drop);
      chk("m_data", out_data, m_last.data);
      chk("m_prop", out_propagate, m_last.prop);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send(input logic [18:0] carry, input logic [18:0] sum,
                      input logic [5:0] sh, input logic prop);
    in_c = {carry, sum};
    in_shift = sh;
    in_propagate = prop;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic pop_expect(input string name, input logic [7:0] d);
    chk({name, "_valid"}, out_valid, 1);
    chk(name, out_data, d);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    idle(2);
    RST = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_data", out_data, 0);

    // Saturation and latency
    send(19'd28, 19'd100, 6'd0, 1'b1);
    step();
    chk("lat_cycle2_valid", out_valid, 0);
    step();
    chk("lat_cycle3_valid", out_valid, 1);
    chk("sat_hi_data", out_data, 8'h7F);
    chk("sat_hi_prop", out_propagate, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("pop_count", fifo_count, 0);
    chk("pop_hold_data", out_data, 8'h7F);

    // Rounding, carry-save wrap, shift clamp
    send(19'd0, 19'd37, 6'd2, 1'b0);
    send(19'd0, 19'h7FFDB, 6'd2, 1'b1);
    send(19'd1, 19'h7FFFF, 6'd0, 1'b0);
    send(19'd0, 19'd5, 6'd40, 1'b1);
    idle(3);
    chk("rnd_count", fifo_count, 4);
    pop_expect("rnd_pos", 8'd9);
    pop_expect("rnd_neg", 8'hF7);
    pop_expect("cs_wrap", 8'd0);
    pop_expect("shift_clamp", 8'd0);
    chk("rnd_empty", out_valid, 0);

    // Overflow with six back-to-back words
    for (int i = 1; i <= 6; i++) send(19'd0, 19'(i), 6'd0, i[0]);
    idle(3);
    chk("ovf_count", fifo_count, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop", drop_cnt, 2);
    pop_expect("ovf_w1", 8'd1);
    pop_expect("ovf_w2", 8'd2);
    pop_expect("ovf_w3", 8'd3);
    pop_expect("ovf_w4", 8'd4);
    chk("ovf_empty", out_valid, 0);

    // Full FIFO with simultaneous push and pop (includes negative saturation)
    send(19'd0, 19'd10, 6'd0, 1'b0);
    send(19'd0, 19'h7FF38, 6'd0, 1'b1);
    send(19'd0, 19'd12, 6'd0, 1'b0);
    send(19'd0, 19'd13, 6'd0, 1'b1);
    idle(3);
    chk("pp_full", fifo_count, 4);
    send(19'd0, 19'd14, 6'd0, 1'b0);
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("pp_count", fifo_count, 4);
    chk("pp_drop", drop_cnt, 2);
    pop_expect("sat_lo", 8'h80);
    pop_expect("pp_w12", 8'd12);
    pop_expect("pp_w13", 8'd13);
    pop_expect("pp_w14", 8'd14);
    chk("pp_empty", out_valid, 0);

    // Reset mid-operation: 3 in FIFO, 2 in pipeline
    send(19'd0, 19'd20, 6'd0, 1'b0);
    send(19'd0, 19'd21, 6'd0, 1'b0);
    send(19'd0, 19'd22, 6'd0, 1'b0);
    idle(3);
    chk("mid_count", fifo_count, 3);
    send(19'd0, 19'd23, 6'd0, 1'b1);
    send(19'd0, 19'd24, 6'd0, 1'b1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_drop", drop_cnt, 0);
    chk("mid_rst_data", out_data, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("mid_no_stale_valid", out_valid, 0);
      chk("mid_no_stale_count", fifo_count, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pe_out_drain.md
Name: pe_out_drain

Overview:
- Downstream consumer of the PE_64 output column.
- Captures each valid carry-save result word from the PE: the carry half plus the sum half.
- Processing steps:
  - resolves the two halves to a binary value;
  - applies a round-half-up arithmetic right shift, controlled by the PE's shift field;
  - saturates the result to the output element width.
- Buffers results in a small FIFO with a valid/ready interface toward the writeback path.
- The PE cannot be stalled, so the block drops input on overflow and reports every drop.

Parameters:
- ACC_W, 19, width of each carry-save half; io_out_c width is 2*ACC_W.
- OUT_W, 8, signed output element width.
- DEPTH, 4, FIFO entries; must be a power of two, at least 2.
- CNT_W, 8, width of the drop counter.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous active-high reset.
- in_c  in  2*ACC_W  PE io_out_c; carry is [2*ACC_W-1:ACC_W], sum is [ACC_W-1:0].
- in_shift  in  6  PE io_out_control_shift; rounding shift amount.
- in_propagate  in  1  PE io_out_control_propagate; carried as a tag.
- in_valid  in  1  PE io_out_valid.
- out_data  out  OUT_W  signed result at the FIFO head.
- out_propagate  out  1  tag of the FIFO head.
- out_valid  out  1  FIFO is not empty.
- out_ready  in  1  consumer accepts the head this cycle.
- fifo_count  out  clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; set on any dropped word.
- drop_cnt  out  CNT_W  saturating count of dropped words.

Behaviour:
- Reset:
  - On RST high at an edge, all pipeline valid bits, FIFO pointers and occupancy clear.
  - overflow and drop_cnt clear; out_data and out_propagate go to 0; out_valid goes to 0.
  - Reset takes priority over every other event, including reset mid-operation; in-flight words are discarded without being counted.
- Stage S1 (registered when in_valid=1):
  - v = (carry + sum) mod 2^ACC_W, interpreted as a signed value.
  - s = min(in_shift, ACC_W).
  - The propagate tag and s are registered alongside v.
- Stage S2:
  - If s = 0, r = v.
  - Otherwise r = (v + 2^(s-1)) >>> s, computed sign-extended in ACC_W+1 bits so the rounding add cannot overflow.
- Stage S3 (saturate, FIFO write):
  - If r > 2^(OUT_W-1)-1, output 2^(OUT_W-1)-1.
  - If r < -2^(OUT_W-1), output -2^(OUT_W-1).
  - Otherwise output r[OUT_W-1:0].
- Latency:
  - in_valid is high in cycle 0 and sampled at edge 1.
  - S1 registers at edge 1, S2 at edge 2, FIFO write at edge 3.
  - With an empty FIFO, out_valid rises in cycle 3.
  - There is no bypass path.
  - Throughput is one word per cycle.
- Pipeline: always advances and is never stalled; bubbles propagate as invalid.
- FIFO pop: occurs when out_valid and out_ready are both high at an edge; the head advances and the read pointer wraps modulo DEPTH.
- FIFO push: occurs when the S3 word is valid, subject to these rules:
  - Not full: the word is written and the write pointer wraps modulo DEPTH.
  - Full with a pop at the same edge: the push is accepted; occupancy stays at DEPTH.
  - Full with no pop: the word is dropped, overflow is set to 1, and drop_cnt increments, saturating at 2^CNT_W-1.
  - Empty with a push: no pop is possible that cycle; out_valid rises the next cycle.
- Output ordering: out_data and out_propagate are driven from the head entry; they hold a stable value while out_valid=1 and out_ready=0. When the FIFO is empty they hold their last value, or 0 after reset.
- overflow: cleared only by RST.

Decomposition:
- Shared package pe_drain_pkg holds:
  - ACC_W and OUT_W defaults;
  - the saturation limit constants;
  - the FIFO entry packing {propagate, data}.
- One natural sub-module, drain_fifo:
  - parameterised synchronous FIFO of width OUT_W+1 and depth DEPTH;
  - provides count, full and empty signals;
  - implements the push-on-full-with-pop rule.
- The round/saturate stages stay inline in pe_out_drain.

Test Plan:
- Saturation and latency: sum=100, carry=28, shift=0, in_valid pulsed in cycle 0 -> out_valid in cycle 3, out_data=127 (0x7F), then one pop leaves fifo_count=0.
- Rounding, positive: sum=37, carry=0, shift=2 -> out_data=9. Rounding, negative: sum=0x7FFDB (-37), carry=0, shift=2 -> out_data=-9 (0xF7).
- Carry-save wrap: sum=0x7FFFF, carry=0x00001, shift=0 -> out_data=0. Shift clamp: value 5, shift=40 -> s=19, out_data=0.
- Overflow: out_ready=0, six back-to-back valid words 1..6 at shift=0 -> fifo_count=4, overflow=1, drop_cnt=2. Then out_ready=1 -> words 1,2,3,4 appear in order, after which out_valid=0.
- Full with simultaneous push/pop: FIFO holds 4 entries, out_ready=1 held while a new word arrives -> no drop, fifo_count stays 4, drop_cnt unchanged.
- Reset mid-operation: RST high for one cycle with 2 words in the pipeline and 3 in the FIFO -> next cycle out_valid=0, fifo_count=0, overflow=0, drop_cnt=0. No stale word emerges in the following 5 cycles.
